// File: rtl/wb_pkg.sv
// Shared types for the queued Wishbone master: command encoding and
// controller state enumeration.
package wb_pkg;

  typedef enum logic [1:0] {
    WISHBONE_CMD_NONE  = 2'd0,
    WISHBONE_CMD_LOAD  = 2'd1,
    WISHBONE_CMD_STORE = 2'd2
  } wb_command_t;

  typedef enum logic {
    WB_STATE_IDLE     = 1'b0,
    WB_STATE_WAIT_ACK = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command queue for wb_master_q: synchronous push/pop, pointers carry an
// extra wrap bit so full and empty are distinguishable.
module wb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr = '0;
  logic [AW:0]      rd_ptr = '0;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in && push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_master_q.sv
// Queued Wishbone classic master: buffers LOAD/STORE commands and runs them
// one at a time. Optional ack timeout enabled by WB_MASTER_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | bus released; pops next queued command when one is present
// WAIT_ACK | cyc/stb asserted, waiting for ack, err or (optionally) timeout
module wb_master_q
  import wb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  wb_command_t         cmd_in,
  output logic                cmd_ready_out,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W/8-1:0] wmask_in,
  output logic                rsp_valid_out,
  output logic                rsp_err_out,
  output logic                rsp_timeout_out,
  output logic [DATA_W-1:0]   rsp_rdata_out,
  output logic                busy_out,
  output logic [ADDR_W-1:0]   wb_addr_out,
  output logic [DATA_W-1:0]   wb_wdata_out,
  output logic [DATA_W/8-1:0] wb_sel_out,
  output logic                wb_we_out,
  output logic                wb_stb_out,
  output logic                wb_cyc_out,
  input  logic [DATA_W-1:0]   wb_rdata_in,
  input  logic                wb_ack_in,
  input  logic                wb_err_in
);

  localparam int SEL_W   = DATA_W / 8;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W + SEL_W;

  localparam logic [0:0] ST_IDLE     = WB_STATE_IDLE;
  localparam logic [0:0] ST_WAIT_ACK = WB_STATE_WAIT_ACK;

  logic               q_push;
  logic               q_pop;
  logic               q_full;
  logic               q_empty;
  logic               is_store;
  logic [ENTRY_W-1:0] q_din;
  logic [ENTRY_W-1:0] q_dout;

  logic [0:0]         state_q     = ST_IDLE;
  logic               cyc_q       = 1'b0;
  logic               we_q        = 1'b0;
  logic               load_q      = 1'b0;
  logic [ADDR_W-1:0]  addr_q      = '0;
  logic [DATA_W-1:0]  wdata_q     = '0;
  logic [SEL_W-1:0]   sel_q       = '0;
  logic               rsp_valid_q = 1'b0;
  logic               rsp_err_q   = 1'b0;
  logic [DATA_W-1:0]  rsp_rdata_q = '0;

  assign is_store = (cmd_in == WISHBONE_CMD_STORE);
  assign q_push   = (is_store || cmd_in == WISHBONE_CMD_LOAD) && !q_full;
  assign q_pop    = (state_q == ST_IDLE);
  // Loads always read the full word, so their mask is forced at enqueue time.
  assign q_din    = {is_store, addr_in, wdata_in, is_store ? wmask_in : {SEL_W{1'b1}}};

  wb_cmd_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(QUEUE_DEPTH)
  ) u_cmd_fifo (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .push    (q_push),
    .din     (q_din),
    .pop     (q_pop),
    .dout    (q_dout),
    .full    (q_full),
    .empty   (q_empty)
  );

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q     = '0;
  logic             rsp_timeout_q = 1'b0;
  assign rsp_timeout_out = rsp_timeout_q;
`else
  assign rsp_timeout_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      load_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!q_empty) begin
            {we_q, addr_q, wdata_q, sel_q} <= q_dout;
            load_q  <= !q_dout[ENTRY_W-1];
            cyc_q   <= 1'b1;
            state_q <= ST_WAIT_ACK;
`ifdef WB_MASTER_TIMEOUT_EN
            // Terminal count at zero gives exactly TIMEOUT_CYCLES cycles of cyc.
            tmo_cnt_q <= TMO_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        default: begin
          if (wb_err_in || wb_ack_in) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= wb_err_in;
            if (!wb_err_in && load_q)
              rsp_rdata_q <= wb_rdata_in;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
          end else if (tmo_cnt_q == '0) begin
            state_q       <= ST_IDLE;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
`endif
          end
        end
      endcase
    end
  end

  assign cmd_ready_out = !q_full;
  assign busy_out      = !q_empty || (state_q == ST_WAIT_ACK);
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_err_out   = rsp_err_q;
  assign rsp_rdata_out = rsp_rdata_q;
  assign wb_addr_out   = addr_q;
  assign wb_wdata_out  = wdata_q;
  assign wb_sel_out    = sel_q;
  assign wb_we_out     = we_q;
  assign wb_stb_out    = cyc_q;
  assign wb_cyc_out    = cyc_q;

endmodule

// File: tb/tb_wb_master_q.sv
// Bench for wb_master_q: directed scenarios plus random traffic, checked
// against an in-order transaction queue model and a behavioural slave.
module tb_wb_master_q;
  import wb_pkg::*;

  localparam int TMO   = 8;
  localparam int DEPTH = 4;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;
  always #5 clk_in = ~clk_in;

  wb_command_t cmd   = WISHBONE_CMD_NONE;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata, wb_addr, wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc;
  logic [31:0] wb_rdata = '0;
  logic        wb_ack   = 1'b0;
  logic        wb_err   = 1'b0;

  wb_master_q #(.DATA_W(32), .ADDR_W(32), .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .cmd_in(cmd), .cmd_ready_out(cmd_ready), .addr_in(addr), .wdata_in(wdata), .wmask_in(wmask),
    .rsp_valid_out(rsp_valid), .rsp_err_out(rsp_err), .rsp_timeout_out(rsp_timeout),
    .rsp_rdata_out(rsp_rdata), .busy_out(busy),
    .wb_addr_out(wb_addr), .wb_wdata_out(wb_wdata), .wb_sel_out(wb_sel), .wb_we_out(wb_we),
    .wb_stb_out(wb_stb), .wb_cyc_out(wb_cyc),
    .wb_rdata_in(wb_rdata), .wb_ack_in(wb_ack), .wb_err_in(wb_err)
  );

  wb_command_t c64_cmd   = WISHBONE_CMD_NONE;
  logic [31:0] c64_addr  = '0;
  logic [63:0] c64_wdata = '0;
  logic [7:0]  c64_wmask = '0;
  logic        c64_ready, c64_rsp_valid, c64_rsp_err, c64_rsp_tmo, c64_busy;
  logic [63:0] c64_rsp_rdata, c64_wb_wdata;
  logic [31:0] c64_wb_addr;
  logic [7:0]  c64_wb_sel;
  logic        c64_wb_we, c64_wb_stb, c64_wb_cyc;
  logic [63:0] c64_wb_rdata = '0;
  logic        c64_wb_ack   = 1'b0;
  logic        c64_wb_err   = 1'b0;

  wb_master_q #(.DATA_W(64), .ADDR_W(32), .QUEUE_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut64 (
    .clk_in(clk_in), .reset_in(reset_in),
    .cmd_in(c64_cmd), .cmd_ready_out(c64_ready), .addr_in(c64_addr), .wdata_in(c64_wdata),
    .wmask_in(c64_wmask),
    .rsp_valid_out(c64_rsp_valid), .rsp_err_out(c64_rsp_err), .rsp_timeout_out(c64_rsp_tmo),
    .rsp_rdata_out(c64_rsp_rdata), .busy_out(c64_busy),
    .wb_addr_out(c64_wb_addr), .wb_wdata_out(c64_wb_wdata), .wb_sel_out(c64_wb_sel),
    .wb_we_out(c64_wb_we), .wb_stb_out(c64_wb_stb), .wb_cyc_out(c64_wb_cyc),
    .wb_rdata_in(c64_wb_rdata), .wb_ack_in(c64_wb_ack), .wb_err_in(c64_wb_err)
  );

  typedef struct {
    logic        st;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } txn_t;

  txn_t        pend_q[$];
  txn_t        exp_q[$];
  txn_t        cur;
  int          checks      = 0;
  int          errors      = 0;
  int          rsp_count   = 0;
  int          wait_cnt    = 0;
  int          delay       = 0;
  int          mode        = 0;   // 0 ack, 1 err, 2 ack+err together
  bit          stall       = 1'b0;
  bit          rand_slave  = 1'b0;
  bit          use_fixed   = 1'b0;
  bit          in_flight   = 1'b0;
  logic [31:0] fixed_rd    = '0;
  logic [31:0] exp_rdata   = '0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void add(logic st, logic [31:0] a, logic [31:0] d, logic [3:0] m);
    txn_t t;
    t.st = st; t.a = a; t.d = d; t.m = m;
    pend_q.push_back(t);
  endfunction

  // One clock of the environment: drive the next pending command, let the
  // slave answer per its policy, then check everything the edge produced.
  task automatic step();
    logic        drove, rdy, cyc_before, do_rsp, exp_err, exp_tmo;
    logic [31:0] rd;
    drove = (pend_q.size() > 0);
    if (drove) begin
      cmd   = pend_q[0].st ? WISHBONE_CMD_STORE : WISHBONE_CMD_LOAD;
      addr  = pend_q[0].a;
      wdata = pend_q[0].d;
      wmask = pend_q[0].m;
    end else begin
      cmd = WISHBONE_CMD_NONE;
    end
    rdy        = cmd_ready;
    cyc_before = wb_cyc;
    do_rsp = 1'b0; exp_err = 1'b0; exp_tmo = 1'b0; rd = '0;
    if (in_flight) begin
      if (!stall && wait_cnt >= delay) begin
        do_rsp   = 1'b1;
        rd       = use_fixed ? fixed_rd : $urandom;
        wb_rdata = rd;
        wb_ack   = (mode != 1);
        wb_err   = (mode != 0);
        exp_err  = (mode != 0);
      end
`ifdef WB_MASTER_TIMEOUT_EN
      else if (wait_cnt == TMO - 1) begin
        do_rsp  = 1'b1;
        exp_err = 1'b1;
        exp_tmo = 1'b1;
      end
`endif
    end
    @(posedge clk_in); #1;
    if (drove && rdy)
      exp_q.push_back(pend_q.pop_front());
    if (do_rsp) begin
      if (!exp_err && !cur.st)
        exp_rdata = rd;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_timeout", rsp_timeout, exp_tmo);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("cyc_drop", wb_cyc, 0);
      rsp_count++;
      in_flight = 1'b0;
      wb_ack    = 1'b0;
      wb_err    = 1'b0;
    end else begin
      check("rsp_valid_idle", rsp_valid, 0);
    end
    if (wb_cyc && !cyc_before) begin
      check("txn_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("wb_addr", wb_addr, cur.a);
        check("wb_we", wb_we, cur.st);
        check("wb_sel", wb_sel, cur.st ? cur.m : 4'hF);
        check("wb_wdata", wb_wdata, cur.d);
      end
      in_flight = 1'b1;
      wait_cnt  = 0;
      if (rand_slave) begin
        delay = $urandom_range(0, 3);
        mode  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
    end else if (wb_cyc) begin
      wait_cnt++;
    end
    check("wb_stb", wb_stb, wb_cyc);
    check("cmd_ready", cmd_ready, exp_q.size() < DEPTH);
    check("busy", busy, (exp_q.size() > 0) || in_flight);
  endtask

  task automatic run_until(int target, int budget);
    int n = 0;
    while (rsp_count < target && n < budget) begin
      step();
      n++;
    end
    check("rsp_count", rsp_count, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("init_cmd_ready", cmd_ready, 1);
    check("init_cyc", wb_cyc, 0);
    @(posedge clk_in); @(posedge clk_in); #1;
    check("rst_cyc", wb_cyc, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_sel", wb_sel, 0);
    reset_in = 1'b1;

    // Single load: cyc from E0+1, acked after 3 cycles with fixed data.
    use_fixed = 1'b1; fixed_rd = 32'hDEADBEEF; delay = 3; mode = 0;
    add(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    step();
    check("load_cyc_at_E0", wb_cyc, 0);
    step();
    check("load_cyc_at_E0p1", wb_cyc, 1);
    check("load_sel", wb_sel, 4'hF);
    run_until(1, 20);
    check("load_rdata", rsp_rdata, 32'hDEADBEEF);
    step();
    use_fixed = 1'b0;

    // ack and err together: error wins, read data held.
    mode = 2; delay = 1;
    add(1'b0, 32'h0000_2000, 32'h0, 4'h0);
    run_until(2, 20);
    check("collide_err", rsp_err, 1);
    check("collide_rdata", rsp_rdata, 32'hDEADBEEF);
    mode = 1;
    add(1'b1, 32'h0000_2004, 32'h1234_5678, 4'h3);
    run_until(3, 20);
    mode = 0;

    // Queue fill behind a stalled load.
    stall = 1'b1;
    add(1'b0, 32'h0000_3000, 32'h0, 4'h0);
    step(); step();
    for (int i = 0; i < 5; i++)
      add(1'b1, 32'h0000_3100 + 32'(i * 4), $urandom, 4'(i + 1));
    for (int i = 0; i < 4; i++) step();
    check("fill_ready_low", cmd_ready, 0);
    step(); step();
    check("fill_fifth_held", pend_q.size(), 1);
    stall = 1'b0; delay = 0;
    run_until(rsp_count + 6, 60);

    // Random traffic with random slave latency and occasional errors.
    rand_slave = 1'b1;
    for (int i = 0; i < 12; i++)
      add(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
    run_until(rsp_count + 12, 200);
    rand_slave = 1'b0; mode = 0; delay = 0;

`ifdef WB_MASTER_TIMEOUT_EN
    // Silent slave: each command aborts after TMO cycles, queue keeps moving.
    stall = 1'b1;
    add(1'b0, 32'h0000_4000, 32'h0, 4'h0);
    add(1'b1, 32'h0000_4004, 32'hA5A5_0000, 4'h8);
    run_until(rsp_count + 2, 40);
    check("tmo_flag", rsp_timeout, 1);
    stall = 1'b0;
    step();
`endif

    // Reset while a load waits with two commands queued behind it.
    stall = 1'b1;
    add(1'b0, 32'h0000_5000, 32'h0, 4'h0);
    add(1'b1, 32'h0000_5004, 32'h1, 4'h1);
    add(1'b1, 32'h0000_5008, 32'h2, 4'h2);
    step(); step(); step();
    check("pre_rst_queued", exp_q.size(), 2);
    check("pre_rst_cyc", wb_cyc, 1);
    cmd = WISHBONE_CMD_NONE;
    reset_in = 1'b0;
    @(posedge clk_in); #1;
    check("mid_rst_cyc", wb_cyc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    reset_in = 1'b1;
    exp_q.delete(); pend_q.delete();
    in_flight = 1'b0; stall = 1'b0; exp_rdata = '0;
    step(); step(); step();
    check("post_rst_rdata", rsp_rdata, 0);

    // 64-bit store: partial mask and wide data pass straight through.
    c64_cmd = WISHBONE_CMD_STORE; c64_addr = 32'h0000_6000;
    c64_wdata = 64'h0123_4567_89AB_CDEF; c64_wmask = 8'h0F;
    @(posedge clk_in); #1;
    c64_cmd = WISHBONE_CMD_NONE;
    @(posedge clk_in); #1;
    check("w64_cyc", c64_wb_cyc, 1);
    check("w64_sel", c64_wb_sel, 8'h0F);
    check("w64_we", c64_wb_we, 1);
    check("w64_wdata", c64_wb_wdata, 64'h0123_4567_89AB_CDEF);
    c64_wb_ack = 1'b1;
    @(posedge clk_in); #1;
    c64_wb_ack = 1'b0;
    check("w64_rsp_valid", c64_rsp_valid, 1);
    check("w64_rsp_err", c64_rsp_err, 0);
    check("w64_cyc_drop", c64_wb_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
